trsq8_sequencer: RTL and testbench

- Instruction-level control unit for the TRSQ8 core: owns the program counter, fetches 15-bit instruction words, and latches each word for the instruction decoder.
- Consumes the decoder's control outputs (jump, return, halt, nop, skip select, SRAM load/store) and sequences each instruction through fetch, decode, execute and memory-wait.
- Produces the one-cycle execute strobe for the ALU/W datapath and the SRAM request handshake.
- Contains a small hardware return stack for call/return.

---
 rtl/trsq8_sequencer_if.sv | 36 +++
 rtl/trsq8_sequencer.sv | 116 +++++++++++
 tb/tb_trsq8_sequencer.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/trsq8_sequencer_if.sv
// trsq8_sequencer_if: instruction fetch, decoder and SRAM handshake signals of the TRSQ8 sequencer
interface trsq8_sequencer_if #(
    parameter int PC_W = 10
) ();
    logic [PC_W-1:0] imem_addr_op;
    logic [14:0]     imem_data_ip;
    logic [14:0]     instr_op;
    logic            jump_ip;
    logic            return_ip;
    logic            halt_ip;
    logic            nop_ip;
    logic [1:0]      sk_sel_ip;
    logic            sram_ld_ip;
    logic            sram_st_ip;
    logic            zero_ip;
    logic            carry_ip;
    logic            exec_en_op;
    logic            sram_req_op;
    logic            sram_we_op;
    logic            sram_ack_ip;
    logic            halted_op;
    logic            stack_err_op;
    logic            step_ip;

    modport master (
        output imem_addr_op, instr_op, exec_en_op, sram_req_op, sram_we_op, halted_op, stack_err_op,
        input  imem_data_ip, jump_ip, return_ip, halt_ip, nop_ip, sk_sel_ip, sram_ld_ip, sram_st_ip,
               zero_ip, carry_ip, sram_ack_ip, step_ip
    );

    modport slave (
        input  imem_addr_op, instr_op, exec_en_op, sram_req_op, sram_we_op, halted_op, stack_err_op,
        output imem_data_ip, jump_ip, return_ip, halt_ip, nop_ip, sk_sel_ip, sram_ld_ip, sram_st_ip,
               zero_ip, carry_ip, sram_ack_ip, step_ip
    );
endinterface

// File: rtl/trsq8_sequencer.sv
// trsq8_sequencer: TRSQ8 fetch/decode/exec/mem-wait sequencer with PC and return stack; define TRSQ8_SINGLE_STEP_EN for stepping out of HALT
module trsq8_sequencer #(
    parameter int PC_W        = 10,
    parameter int STACK_DEPTH = 4
) (
    input logic               clk_ip,
    input logic               rst_ip,
    trsq8_sequencer_if.master bus
);
    localparam int IDX_W = $clog2(STACK_DEPTH);
    localparam int SP_W  = IDX_W + 1;

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_HALT} state_t;

    state_t           state_q, state_d, done_state;
    logic [PC_W-1:0]  pc_q, pc_d, pc_inc;
    logic [14:0]      instr_q;
    logic [SP_W-1:0]  sp_q, sp_d;
    logic [PC_W-1:0]  stk_q [STACK_DEPTH];
    logic [IDX_W-1:0] top_idx, wr_idx;
    logic             err_q, err_d;
    logic             full, empty, is_mem, exec_pc, skip, push, pop, step_go;

`ifdef TRSQ8_SINGLE_STEP_EN
    logic step_mode_q;
    assign step_go    = state_q == S_HALT && bus.step_ip;
    assign done_state = step_mode_q ? S_HALT : S_FETCH;
    // Once a step has been taken, every completed instruction parks the core back in HALT
    always_ff @(posedge clk_ip or posedge rst_ip)
        if (rst_ip)       step_mode_q <= 1'b0;
        else if (step_go) step_mode_q <= 1'b1;
`else
    logic unused_step;
    assign unused_step = bus.step_ip;
    assign step_go     = 1'b0;
    assign done_state  = S_FETCH;
`endif

    assign pc_inc  = pc_q + PC_W'(1);
    assign is_mem  = bus.sram_ld_ip | bus.sram_st_ip;
    assign exec_pc = state_q == S_EXEC && !bus.halt_ip && !is_mem;
    assign skip    = !bus.nop_ip && ((bus.sk_sel_ip == 2'b01 && bus.zero_ip) ||
                                     (bus.sk_sel_ip == 2'b10 && bus.carry_ip));
    assign push    = exec_pc && bus.jump_ip && instr_q[12];
    assign pop     = exec_pc && !bus.jump_ip && bus.return_ip;
    assign full    = sp_q == SP_W'(STACK_DEPTH);
    assign empty   = sp_q == '0;
    assign top_idx = IDX_W'(sp_q - SP_W'(1));
    // A push onto a full stack overwrites the top entry instead of advancing
    assign wr_idx  = full ? IDX_W'(STACK_DEPTH - 1) : IDX_W'(sp_q);

    assign bus.imem_addr_op = pc_q;
    assign bus.instr_op     = instr_q;
    assign bus.stack_err_op = err_q;

    // State register
    always_ff @(posedge clk_ip or posedge rst_ip)
        if (rst_ip) state_q <= S_FETCH;
        else        state_q <= state_d;

    // Next-state: halt wins over memory access, memory waits for ack with no timeout
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: state_d = S_EXEC;
            S_EXEC:   state_d = bus.halt_ip ? S_HALT : is_mem ? S_MEM : done_state;
            S_MEM:    state_d = bus.sram_ack_ip ? done_state : S_MEM;
            S_HALT:   state_d = step_go ? S_FETCH : S_HALT;
            default:  state_d = S_FETCH;
        endcase
    end

    // State-decoded outputs; reset forces FETCH so the SRAM request drops immediately
    always_comb begin
        bus.exec_en_op  = state_q == S_EXEC;
        bus.sram_req_op = state_q == S_MEM;
        bus.sram_we_op  = state_q == S_MEM && bus.sram_st_ip;
        bus.halted_op   = state_q == S_HALT;
    end

    // Next pc with jump > return > skip > increment priority, plus stack pointer and sticky error
    always_comb begin
        pc_d = pc_q;
        if (exec_pc)
            pc_d = bus.jump_ip   ? instr_q[PC_W-1:0] :
                   bus.return_ip ? (empty ? '0 : stk_q[top_idx]) :
                   skip          ? pc_q + PC_W'(2) : pc_inc;
        else if ((state_q == S_MEM && bus.sram_ack_ip) || step_go)
            pc_d = pc_inc;
        sp_d  = sp_q + SP_W'(push && !full) - SP_W'(pop && !empty);
        err_d = err_q | (push && full) | (pop && empty);
    end

    // Program counter, instruction latch, stack pointer and error flag
    always_ff @(posedge clk_ip or posedge rst_ip)
        if (rst_ip) begin
            pc_q    <= '0;
            instr_q <= '0;
            sp_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            sp_q  <= sp_d;
            err_q <= err_d;
            if (state_q == S_DECODE) instr_q <= bus.imem_data_ip;
        end

    // Return stack storage; a call stores the address after itself
    always_ff @(posedge clk_ip or posedge rst_ip)
        if (rst_ip) begin
            for (int i = 0; i < STACK_DEPTH; i++) stk_q[i] <= '0;
        end else if (push) begin
            stk_q[wr_idx] <= pc_inc;
        end
endmodule

// File: tb/tb_trsq8_sequencer.sv
// tb_trsq8_sequencer: directed and randomized checks of the TRSQ8 sequencer against an instruction-level model
module tb_trsq8_sequencer;
    localparam int PC_W    = 10;
    localparam int DEPTH   = 4;
    localparam int MASK    = (1 << PC_W) - 1;
    localparam int OP_HALT = 1;
    localparam int OP_RET  = 2;
    localparam int OP_SKZ  = 3;
    localparam int OP_SKC  = 4;
    localparam int OP_LD   = 5;
    localparam int OP_ST   = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;

    trsq8_sequencer_if #(.PC_W(PC_W)) bus ();
    trsq8_sequencer #(.PC_W(PC_W), .STACK_DEPTH(DEPTH)) dut (.clk_ip(clk), .rst_ip(rst), .bus(bus));

    always #5 clk = ~clk;

    logic [14:0] rom [1 << PC_W];
    int          ack_delay;
    int          mem_cnt;
    logic        stray_ack;
    bit          noise;
    int          passed, total;
    int          m_pc;
    int          m_stk [$];
    logic        m_err;

    // Bench instruction set: 01 c tttttttttttt = jump/call, 10 0 ooo ... = misc op, anything else = NOP
    wire [1:0] cls  = bus.instr_op[14:13];
    wire [2:0] opc  = bus.instr_op[11:9];
    wire       misc = cls == 2'b10;
    assign bus.jump_ip    = cls == 2'b01;
    assign bus.halt_ip    = misc && opc == 3'd1;
    assign bus.return_ip  = misc && opc == 3'd2;
    assign bus.sk_sel_ip  = !misc ? 2'b00 : opc == 3'd3 ? 2'b01 : opc == 3'd4 ? 2'b10 : 2'b00;
    assign bus.sram_ld_ip = misc && opc == 3'd5;
    assign bus.sram_st_ip = misc && opc == 3'd6;
    assign bus.nop_ip     = !bus.jump_ip && !(misc && opc >= 3'd1 && opc <= 3'd6);
    assign bus.sram_ack_ip = bus.sram_req_op ? (mem_cnt == ack_delay) : stray_ack;

    always @(posedge clk) bus.imem_data_ip <= rom[bus.imem_addr_op];

    always @(posedge clk or posedge rst)
        if (rst) mem_cnt <= 0;
        else     mem_cnt <= (bus.sram_req_op && !bus.sram_ack_ip) ? mem_cnt + 1 : 0;

    function automatic logic [14:0] f_jmp(int t);
        return {2'b01, 1'b0, 12'(t)};
    endfunction

    function automatic logic [14:0] f_call(int t);
        return {2'b01, 1'b1, 12'(t)};
    endfunction

    function automatic logic [14:0] f_op(int o);
        return {2'b10, 1'b0, 3'(o), 9'b0};
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (noise) begin
            bus.zero_ip  = 1'($urandom);
            bus.carry_ip = 1'($urandom);
            bus.step_ip  = $urandom_range(0, 7) == 0;
            stray_ack    = $urandom_range(0, 3) == 0;
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i <= MASK; i++) rom[i] = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_addr", bus.imem_addr_op, 0);
        chk("rst_instr", bus.instr_op, 0);
        chk("rst_exec", bus.exec_en_op, 0);
        chk("rst_req", bus.sram_req_op, 0);
        chk("rst_we", bus.sram_we_op, 0);
        chk("rst_halted", bus.halted_op, 0);
        chk("rst_err", bus.stack_err_op, 0);
        tick();
        tick();
        rst   = 1'b0;
        m_pc  = 0;
        m_err = 1'b0;
        m_stk.delete();
    endtask

    // Runs one instruction starting in its FETCH cycle and ends in the following FETCH (or HALT) cycle
    task automatic exec_one(int fixed_delay);
        logic [14:0] w;
        logic        z, c;
        int          o, d;
        w = rom[m_pc];
        o = w[14:13] == 2'b10 ? int'(w[11:9]) : 0;
        chk("fetch_addr", bus.imem_addr_op, m_pc);
        chk("fetch_exec", bus.exec_en_op, 0);
        chk("stack_err", bus.stack_err_op, m_err);
        tick();
        tick();
        chk("exec_en", bus.exec_en_op, 1);
        chk("instr", bus.instr_op, w);
        z = bus.zero_ip;
        c = bus.carry_ip;
        if (o == OP_HALT) begin
            tick();
            return;
        end
        if (o == OP_LD || o == OP_ST) begin
            d = fixed_delay >= 0 ? fixed_delay : $urandom_range(0, 3);
            ack_delay = d;
            for (int k = 0; k <= d; k++) begin
                tick();
                chk("mem_req", bus.sram_req_op, 1);
                chk("mem_we", bus.sram_we_op, o == OP_ST);
            end
            m_pc = (m_pc + 1) & MASK;
        end else if (w[14:13] == 2'b01) begin
            if (w[12]) begin
                if (m_stk.size() == DEPTH) begin
                    m_stk[DEPTH-1] = (m_pc + 1) & MASK;
                    m_err = 1'b1;
                end else begin
                    m_stk.push_back((m_pc + 1) & MASK);
                end
            end
            m_pc = int'(w) & MASK;
        end else if (o == OP_RET) begin
            if (m_stk.size() == 0) begin
                m_pc  = 0;
                m_err = 1'b1;
            end else begin
                m_pc = m_stk.pop_back();
            end
        end else begin
            m_pc = (m_pc + (((o == OP_SKZ && z) || (o == OP_SKC && c)) ? 2 : 1)) & MASK;
        end
        tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int r;
        passed = 0;
        total = 0;
        noise = 1'b0;
        stray_ack = 1'b0;
        ack_delay = 0;
        bus.zero_ip = 1'b0;
        bus.carry_ip = 1'b0;
        bus.step_ip = 1'b0;
        clear_rom();

        do_reset();
        noise = 1'b1;
        for (int i = 0; i < 9; i++) begin
            chk("nop_addr", bus.imem_addr_op, i / 3);
            chk("nop_exec", bus.exec_en_op, i % 3 == 2);
            chk("nop_halted", bus.halted_op, 0);
            tick();
        end
        m_pc = 3;

        rom[5] = f_op(OP_SKZ);
        rom[6] = f_op(OP_SKC);
        rom[7] = f_jmp(5);
        exec_one(-1);
        exec_one(-1);
        noise = 1'b0;
        bus.zero_ip = 1'b1;
        bus.carry_ip = 1'b0;
        exec_one(-1);
        chk("skz_taken", bus.imem_addr_op, 7);
        exec_one(-1);
        bus.zero_ip = 1'b0;
        exec_one(-1);
        chk("skz_not_taken", bus.imem_addr_op, 6);
        bus.zero_ip = 1'b1;
        bus.carry_ip = 1'b1;
        exec_one(-1);
        chk("skc_taken", bus.imem_addr_op, 8);

        do_reset();
        clear_rom();
        noise = 1'b1;
        rom[0] = f_jmp('h10);
        rom['h10] = f_call('h40);
        rom['h40] = f_op(OP_RET);
        exec_one(-1);
        exec_one(-1);
        chk("call_target", bus.imem_addr_op, 'h40);
        exec_one(-1);
        chk("return_addr", bus.imem_addr_op, 'h11);
        chk("call_err", bus.stack_err_op, 0);

        do_reset();
        clear_rom();
        rom[0] = f_jmp('h100);
        for (int i = 0; i < 5; i++) begin
            rom['h100 + 16 * i] = f_call('h110 + 16 * i);
            rom['h101 + 16 * i] = f_op(OP_RET);
        end
        rom['h150] = f_op(OP_RET);
        exec_one(-1);
        for (int i = 0; i < 5; i++) begin
            exec_one(-1);
            chk("nest_err", bus.stack_err_op, i == 4);
        end
        for (int i = 0; i < 5; i++) exec_one(-1);
        chk("underflow_pc", bus.imem_addr_op, 0);
        chk("underflow_err", bus.stack_err_op, 1);

        do_reset();
        clear_rom();
        rom[0] = f_op(OP_ST);
        rom[1] = f_op(OP_ST);
        exec_one(3);
        chk("store_pc", bus.imem_addr_op, 1);
        chk("store_req_drop", bus.sram_req_op, 0);
        tick();
        tick();
        ack_delay = 3;
        tick();
        chk("midwait_req", bus.sram_req_op, 1);
        tick();
        rst = 1'b1;
        #1;
        chk("rst_drops_req", bus.sram_req_op, 0);
        do_reset();

        clear_rom();
        noise = 1'b0;
        bus.step_ip = 1'b0;
        stray_ack = 1'b0;
        rom[3] = f_op(OP_HALT);
        for (int i = 0; i < 4; i++) exec_one(-1);
        for (int i = 0; i < 6; i++) begin
            chk("halted", bus.halted_op, 1);
            chk("halt_addr", bus.imem_addr_op, 3);
            tick();
        end
        bus.step_ip = 1'b1;
        tick();
        bus.step_ip = 1'b0;
`ifdef TRSQ8_SINGLE_STEP_EN
        m_pc = 4;
        exec_one(-1);
        for (int i = 0; i < 3; i++) begin
            chk("step_halted", bus.halted_op, 1);
            chk("step_addr", bus.imem_addr_op, 5);
            tick();
        end
`else
        for (int i = 0; i < 3; i++) begin
            chk("step_ignored", bus.halted_op, 1);
            chk("step_addr", bus.imem_addr_op, 3);
            tick();
        end
`endif

        do_reset();
        for (int i = 0; i <= MASK; i++) begin
            r = $urandom_range(0, 99);
            rom[i] = r < 20 ? 15'h0000 :
                     r < 32 ? f_jmp($urandom_range(0, MASK)) :
                     r < 44 ? f_call($urandom_range(0, MASK)) :
                     r < 58 ? f_op(OP_RET) :
                     r < 70 ? f_op(OP_SKZ) :
                     r < 80 ? f_op(OP_SKC) :
                     r < 90 ? f_op(OP_LD) : f_op(OP_ST);
        end
        noise = 1'b1;
        for (int i = 0; i < 250; i++) exec_one(-1);
        chk("rand_final_addr", bus.imem_addr_op, m_pc);
        chk("rand_final_err", bus.stack_err_op, m_err);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
